sd_seq_gen: RTL and testbench

SD_SEQ_GEN -- requirements
Module: sd_seq_gen

---
 rtl/sd_seq_pkg.sv | 13 +
 rtl/sd_seq_gen_if.sv | 11 +
 rtl/sd_lfsr16.sv | 32 +++
 rtl/sd_seq_gen.sv | 128 ++++++++++++
 tb/tb_sd_seq_gen.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_seq_pkg.sv
// Shared types and constants for the sequence generator slice.
package sd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/sd_seq_gen_if.sv
// Producer-side srdy/drdy handshake bundle.
interface sd_seq_gen_if #(
  parameter int unsigned width = 16
);
  logic             p_srdy;
  logic             p_drdy;
  logic [width-1:0] p_data;

  modport master (output p_srdy, output p_data, input p_drdy);
  modport slave  (input p_srdy, input p_data, output p_drdy);
endinterface

// File: rtl/sd_lfsr16.sv
// 16-bit Galois LFSR that advances only while enabled.
module sd_lfsr16
  import sd_seq_pkg::*;
#(
  parameter logic [15:0] seed = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  // Next-state: shift right, fold taps back in when the output bit is set
  always_comb begin
    value_d = value_q;
    if (enable) begin
      value_d = {1'b0, value_q[15:1]} ^ (value_q[0] ? LFSR_TAPS : '0);
    end
  end

  // State register, restarts from the seed on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) value_q <= seed;
    else          value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/sd_seq_gen.sv
// Arithmetic-sequence producer with LFSR-driven idle insertion.
module sd_seq_gen
  import sd_seq_pkg::*;
#(
  parameter int unsigned width     = 16,
  parameter logic [15:0] lfsr_seed = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_start,
  input  logic [15:0]       cfg_len,
  input  logic [width-1:0]  cfg_init,
  input  logic [width-1:0]  cfg_incr,
  input  logic [15:0]       cfg_gap_mask,
  sd_seq_gen_if.master      p,
  output logic              busy,
  output logic              done,
  output logic [31:0]       out_count
);

  seq_state_e       state_q,  state_d;
  logic             srdy_q,   srdy_d;
  logic [width-1:0] data_q,   data_d;
  logic [width-1:0] incr_q,   incr_d;
  logic [15:0]      mask_q,   mask_d;
  logic [15:0]      remain_q, remain_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [31:0]      count_q,  count_d;

  logic [15:0] lfsr;
  logic        xfer;

  assign xfer = srdy_q & p.p_drdy;

  sd_lfsr16 #(.seed(lfsr_seed)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (state_q == RUN),
    .value   (lfsr)
  );

  // Sequencer next-state; data_q always holds the item currently offered or next to offer
  always_comb begin
    state_d  = state_q;
    srdy_d   = srdy_q;
    data_d   = data_q;
    incr_d   = incr_q;
    mask_d   = mask_q;
    remain_d = remain_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    count_d  = count_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          data_d   = cfg_init;
          incr_d   = cfg_incr;
          mask_d   = cfg_gap_mask;
          remain_d = cfg_len;
          if (cfg_len != 16'd0) begin
            state_d = RUN;
            busy_d  = 1'b1;
            srdy_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (xfer) begin
          count_d  = count_q + 32'd1;
          remain_d = remain_q - 16'd1;
          data_d   = data_q + incr_q;
        end
        if (xfer && remain_q == 16'd1) begin
          state_d = DONE;
          busy_d  = 1'b0;
          srdy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (!srdy_q || xfer) begin
          srdy_d = ((lfsr & mask_q) == '0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        srdy_d  = 1'b0;
      end
    endcase
  end

  // All architectural state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      srdy_q   <= 1'b0;
      data_q   <= '0;
      incr_q   <= '0;
      mask_q   <= '0;
      remain_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      srdy_q   <= srdy_d;
      data_q   <= data_d;
      incr_q   <= incr_d;
      mask_q   <= mask_d;
      remain_q <= remain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      count_q  <= count_d;
    end
  end

  assign p.p_srdy  = srdy_q;
  assign p.p_data  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_sd_seq_gen.sv
// Directed and table-driven bench for sd_seq_gen (16-bit and 8-bit instances).
module tb_sd_seq_gen;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        cfg_start;
  logic [15:0] cfg_len, cfg_init, cfg_incr, cfg_gap_mask;
  logic        busy, done;
  logic [31:0] out_count;

  logic        cfg8_start;
  logic [15:0] cfg8_len;
  logic [7:0]  cfg8_init, cfg8_incr;
  logic        busy8, done8;
  logic [31:0] count8;

  sd_seq_gen_if #(.width(16)) bus ();
  sd_seq_gen_if #(.width(8))  bus8 ();

  sd_seq_gen #(.width(16), .lfsr_seed(SEED)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .cfg_init(cfg_init), .cfg_incr(cfg_incr), .cfg_gap_mask(cfg_gap_mask),
    .p(bus), .busy(busy), .done(done), .out_count(out_count)
  );

  sd_seq_gen #(.width(8), .lfsr_seed(SEED)) dut8 (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg8_start), .cfg_len(cfg8_len),
    .cfg_init(cfg8_init), .cfg_incr(cfg8_incr), .cfg_gap_mask(16'h0000),
    .p(bus8), .busy(busy8), .done(done8), .out_count(count8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [15:0] lfsr_m;
  bit          gap_chk;
  logic        exp_srdy;
  logic [15:0] exp_data, m_incr, m_mask;
  int          m_remain, n_xfer;
  logic [31:0] exp_count;

  typedef struct {
    logic [15:0]       len;
    logic [15:0]       init;
    logic [15:0]       incr;
    logic [3:0][15:0]  exp_d;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Evaluates the current cycle (inputs already driven) and advances the model.
  task automatic observe();
    if (busy === 1'b1) begin
      if (gap_chk) begin
        chk("srdy_gap", {31'd0, bus.p_srdy}, {31'd0, exp_srdy});
        if (bus.p_srdy && bus.p_drdy) begin
          chk("rand_data", {16'd0, bus.p_data}, {16'd0, exp_data});
          exp_data = exp_data + m_incr;
          n_xfer++;
          m_remain--;
        end
        if (bus.p_srdy && bus.p_drdy && m_remain == 0) exp_srdy = 1'b0;
        else if (!bus.p_srdy || bus.p_drdy) exp_srdy = ((lfsr_m & m_mask) == 16'h0);
      end
      lfsr_m = lfsr_next(lfsr_m);
    end
  endtask

  task automatic clk_cycle();
    observe();
    @(negedge clk);
  endtask

  task automatic start(input logic [15:0] len, input logic [15:0] init,
                       input logic [15:0] incr, input logic [15:0] mask);
    cfg_len = len; cfg_init = init; cfg_incr = incr; cfg_gap_mask = mask;
    cfg_start = 1'b1;
    clk_cycle();
    cfg_start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w8_exp[4];
    reset_n = 1'b0;
    cfg_start = 1'b0; cfg_len = '0; cfg_init = '0; cfg_incr = '0; cfg_gap_mask = '0;
    cfg8_start = 1'b0; cfg8_len = '0; cfg8_init = '0; cfg8_incr = '0;
    bus.p_drdy = 1'b0; bus8.p_drdy = 1'b1;
    lfsr_m = SEED; gap_chk = 0; exp_count = '0;
    exp_srdy = 1'b0; exp_data = '0; m_incr = '0; m_mask = '0; m_remain = 0; n_xfer = 0;

    vecs[0] = '{16'd4,     16'd10,    16'd3,     {16'd19,    16'd16,    16'd13,    16'd10}};
    vecs[1] = '{16'd3,     16'd100,   16'hFFFF,  {16'd0,     16'd98,    16'd99,    16'd100}};
    vecs[2] = '{16'd4,     16'hFFF0,  16'd8,     {16'h0008,  16'h0000,  16'hFFF8,  16'hFFF0}};
    vecs[3] = '{16'd1,     16'd7,     16'd5,     {16'd0,     16'd0,     16'd0,     16'd7}};
    vecs[4] = '{16'd2,     16'd0,     16'h8000,  {16'd0,     16'd0,     16'h8000,  16'd0}};

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_srdy",  {31'd0, bus.p_srdy}, 32'd0);
    chk("rst_data",  {16'd0, bus.p_data}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_count", out_count, 32'd0);
    reset_n = 1'b1;
    clk_cycle();
    clk_cycle();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // table: back-to-back sequences with gap mask 0 and consumer always ready
    for (int v = 0; v < 5; v++) begin
      bus.p_drdy = 1'b1;
      start(vecs[v].len, vecs[v].init, vecs[v].incr, 16'h0000);
      for (int k = 0; k < int'(vecs[v].len); k++) begin
        chk("tbl_srdy", {31'd0, bus.p_srdy}, 32'd1);
        chk("tbl_data", {16'd0, bus.p_data}, {16'd0, vecs[v].exp_d[k]});
        chk("tbl_busy", {31'd0, busy}, 32'd1);
        clk_cycle();
      end
      chk("tbl_done", {31'd0, done}, 32'd1);
      chk("tbl_busy_end", {31'd0, busy}, 32'd0);
      chk("tbl_srdy_end", {31'd0, bus.p_srdy}, 32'd0);
      exp_count = exp_count + {16'd0, vecs[v].len};
      chk("tbl_count", out_count, exp_count);
      clk_cycle();
      chk("tbl_done_pulse", {31'd0, done}, 32'd0);
    end

    // zero-length sequence: done straight away, nothing offered
    start(16'd0, 16'd5, 16'd1, 16'h0000);
    chk("len0_done", {31'd0, done}, 32'd1);
    chk("len0_busy", {31'd0, busy}, 32'd0);
    chk("len0_srdy", {31'd0, bus.p_srdy}, 32'd0);
    clk_cycle();
    chk("len0_done_end", {31'd0, done}, 32'd0);
    chk("len0_busy_end", {31'd0, busy}, 32'd0);
    chk("len0_count", out_count, exp_count);

    // consumer stall: item held, and a start during RUN is ignored
    bus.p_drdy = 1'b0;
    start(16'd3, 16'd50, 16'd2, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      chk("stall_srdy", {31'd0, bus.p_srdy}, 32'd1);
      chk("stall_data", {16'd0, bus.p_data}, 32'd50);
      if (i == 2) begin
        cfg_len = 16'd1; cfg_init = 16'd900; cfg_start = 1'b1;
      end
      clk_cycle();
      cfg_start = 1'b0;
    end
    bus.p_drdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_rel_srdy", {31'd0, bus.p_srdy}, 32'd1);
      chk("stall_rel_data", {16'd0, bus.p_data}, 32'd50 + 32'(2 * k));
      clk_cycle();
    end
    chk("stall_done", {31'd0, done}, 32'd1);
    exp_count = exp_count + 32'd3;
    chk("stall_count", out_count, exp_count);
    clk_cycle();

    // 8-bit instance: data wraps modulo 2^8
    w8_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    cfg8_len = 16'd4; cfg8_init = 8'hFE; cfg8_incr = 8'd1; cfg8_start = 1'b1;
    clk_cycle();
    cfg8_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("w8_srdy", {31'd0, bus8.p_srdy}, 32'd1);
      chk("w8_data", {24'd0, bus8.p_data}, {24'd0, w8_exp[k]});
      clk_cycle();
    end
    chk("w8_done", {31'd0, done8}, 32'd1);
    chk("w8_count", count8, 32'd4);
    clk_cycle();

    // asynchronous reset after two of five items
    bus.p_drdy = 1'b1;
    start(16'd5, 16'd200, 16'd10, 16'h0000);
    chk("rs_data0", {16'd0, bus.p_data}, 32'd200);
    clk_cycle();
    chk("rs_data1", {16'd0, bus.p_data}, 32'd210);
    clk_cycle();
    #2;
    reset_n = 1'b0;
    lfsr_m = SEED;
    exp_count = '0;
    #1;
    chk("rs_srdy",  {31'd0, bus.p_srdy}, 32'd0);
    chk("rs_data",  {16'd0, bus.p_data}, 32'd0);
    chk("rs_busy",  {31'd0, busy}, 32'd0);
    chk("rs_done",  {31'd0, done}, 32'd0);
    chk("rs_count", out_count, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rs_no_done", {31'd0, done}, 32'd0);
      chk("rs_no_srdy", {31'd0, bus.p_srdy}, 32'd0);
      clk_cycle();
    end
    start(16'd2, 16'd200, 16'd10, 16'h0000);
    chk("rs2_data0", {16'd0, bus.p_data}, 32'd200);
    clk_cycle();
    chk("rs2_data1", {16'd0, bus.p_data}, 32'd210);
    clk_cycle();
    chk("rs2_done", {31'd0, done}, 32'd1);
    exp_count = exp_count + 32'd2;
    chk("rs2_count", out_count, exp_count);
    clk_cycle();

    // random consumer with idle insertion; the LFSR is never zero, so a
    // mask covering all 16 bits would idle forever -- use a sparse mask
    gap_chk = 1; m_incr = 16'd7; m_mask = 16'h0005; exp_data = 16'd1000;
    m_remain = 100; n_xfer = 0; exp_srdy = 1'b1;
    start(16'd100, 16'd1000, 16'd7, 16'h0005);
    for (int c = 0; c < 5000 && n_xfer < 100; c++) begin
      bus.p_drdy = 1'($urandom_range(0, 1));
      clk_cycle();
    end
    chk("rand_xfers", n_xfer, 32'd100);
    chk("rand_done", {31'd0, done}, 32'd1);
    chk("rand_srdy_end", {31'd0, bus.p_srdy}, 32'd0);
    exp_count = exp_count + 32'd100;
    chk("rand_count", out_count, exp_count);
    clk_cycle();
    gap_chk = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
